// File: rtl/decode_pkg.sv
// Shared opcode constants, format tag and immediate builder for the decode stage.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL} fmt_e;

  // Always built at 64 bits; callers truncate to their XLEN.
  function automatic logic [63:0] imm_gen(input fmt_e fmt, input logic [31:0] ins);
    logic [63:0] imm;
    case (fmt)
      FMT_I:   imm = {{52{ins[31]}}, ins[31:20]};
      FMT_S:   imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm = {{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm = {{32{ins[31]}}, ins[31:12], 12'b0};
      FMT_J:   imm = {{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
  import decode_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  fmt_e            out_fmt;
  logic            out_rd_we;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
  );
endinterface

// File: rtl/decode_fifo.sv
// Generic DEPTH-entry ring buffer; head data reads zero while empty.
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_pop_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  // Ready depends only on the registered count, never on i_pop_ready.
  assign o_push_ready = (r_count != CW'(DEPTH));
  assign o_pop_valid  = (r_count != '0);
  assign o_pop_data   = o_pop_valid ? r_mem[r_rptr] : '0;

  assign w_push = i_push_valid & o_push_ready & ~flush;
  assign w_pop  = o_pop_valid & i_pop_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (flush) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end
endmodule

// File: rtl/decode_stage.sv
// RV32I/RV64I decoder feeding a DEPTH-entry buffer of uniform decoded entries.
// Optional DECODE_STATS_EN adds saturating push / illegal-push counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  decode_stage_if.slave bus
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0] stat_decoded,
  output logic [31:0] stat_illegal
`endif
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            rd_we;
    logic            illegal;
  } dec_entry_t;

  logic [6:0] w_op, w_f7, w_shup;
  logic [2:0] w_f3;
  fmt_e       w_fmt;
  logic       w_bad, w_ill;
  dec_entry_t w_ent, w_head;

  assign w_op = bus.in_instr[6:0];
  assign w_f3 = bus.in_instr[14:12];
  assign w_f7 = bus.in_instr[31:25];
  // Shift-immediate upper bits, left-aligned so 0x20 means "arithmetic" at both widths.
  assign w_shup = (XLEN == 64) ? {bus.in_instr[31:26], 1'b0} : bus.in_instr[31:25];

  always_comb begin
    w_fmt = FMT_ILL;
    case (w_op)
      OPC_OP:                                     w_fmt = FMT_R;
      OPC_OP_32:                                  w_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: w_fmt = FMT_I;
      OPC_OP_IMM_32:                              w_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
      OPC_STORE:                                  w_fmt = FMT_S;
      OPC_BRANCH:                                 w_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                         w_fmt = FMT_U;
      OPC_JAL:                                    w_fmt = FMT_J;
      default:                                    w_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    w_bad = 1'b0;
    if (w_fmt == FMT_R)
      w_bad = (w_f7 != 7'h00 && w_f7 != 7'h20) ||
              (w_f7 == 7'h20 && w_f3 != 3'b000 && w_f3 != 3'b101);
    if (w_op == OPC_OP_IMM && w_f3 == 3'b001 && w_shup != 7'h00)
      w_bad = 1'b1;
    if (w_op == OPC_OP_IMM && w_f3 == 3'b101 && w_shup != 7'h00 && w_shup != 7'h20)
      w_bad = 1'b1;
    if (w_op == OPC_JALR && w_f3 != 3'b000)
      w_bad = 1'b1;
    if (w_op == OPC_BRANCH && (w_f3 == 3'b010 || w_f3 == 3'b011))
      w_bad = 1'b1;
  end

  assign w_ill = (w_fmt == FMT_ILL) || w_bad;

  always_comb begin
    w_ent        = '0;
    w_ent.pc     = bus.in_pc;
    w_ent.opcode = w_op;
    if (w_ill) begin
      w_ent.fmt     = FMT_ILL;
      w_ent.illegal = 1'b1;
    end else begin
      w_ent.fmt    = w_fmt;
      w_ent.rd     = (w_fmt inside {FMT_S, FMT_B}) ? 5'd0 : bus.in_instr[11:7];
      w_ent.rs1    = (w_fmt inside {FMT_U, FMT_J}) ? 5'd0 : bus.in_instr[19:15];
      w_ent.rs2    = (w_fmt inside {FMT_R, FMT_S, FMT_B}) ? bus.in_instr[24:20] : 5'd0;
      w_ent.funct3 = (w_fmt inside {FMT_U, FMT_J}) ? 3'd0 : w_f3;
      w_ent.funct7 = (w_fmt == FMT_R) ? w_f7 : 7'd0;
      w_ent.imm    = XLEN'(imm_gen(w_fmt, bus.in_instr));
      w_ent.rd_we  = (w_ent.rd != 5'd0);
    end
  end

  decode_fifo #(.WIDTH($bits(dec_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .i_push_valid (bus.in_valid),
    .o_push_ready (bus.in_ready),
    .i_push_data  (w_ent),
    .o_pop_valid  (bus.out_valid),
    .i_pop_ready  (bus.out_ready),
    .o_pop_data   (w_head)
  );

  assign bus.out_pc      = w_head.pc;
  assign bus.out_opcode  = w_head.opcode;
  assign bus.out_rd      = w_head.rd;
  assign bus.out_rs1     = w_head.rs1;
  assign bus.out_rs2     = w_head.rs2;
  assign bus.out_funct3  = w_head.funct3;
  assign bus.out_funct7  = w_head.funct7;
  assign bus.out_imm     = w_head.imm;
  assign bus.out_fmt     = w_head.fmt;
  assign bus.out_rd_we   = w_head.rd_we;
  assign bus.out_illegal = w_head.illegal;

`ifdef DECODE_STATS_EN
  logic        w_push;
  logic [31:0] r_stat_dec, r_stat_ill;

  assign w_push = bus.in_valid & bus.in_ready & ~flush;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_dec <= '0;
      r_stat_ill <= '0;
    end else if (w_push) begin
      if (r_stat_dec != '1)         r_stat_dec <= r_stat_dec + 32'd1;
      if (w_ill && r_stat_ill != '1) r_stat_ill <= r_stat_ill + 32'd1;
    end
  end

  assign stat_decoded = r_stat_dec;
  assign stat_illegal = r_stat_ill;
`endif
endmodule
